// File: rtl/excp_redirect_ctrl_pkg.sv
// Shared definitions for the exception/interrupt commit controller.
package excp_redirect_ctrl_pkg;

   localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;
   localparam int unsigned EXCODE_W_DEF = 5;
   localparam int unsigned INT_W_DEF    = 8;
   localparam int unsigned CNT_W_DEF    = 16;

   localparam logic [EXCODE_W_DEF-1:0] EXCODE_INT  = 5'h00;
   localparam logic [EXCODE_W_DEF-1:0] EXCODE_ADEL = 5'h04;
   localparam logic [EXCODE_W_DEF-1:0] EXCODE_ADES = 5'h05;
   localparam logic [EXCODE_W_DEF-1:0] EXCODE_SYS  = 5'h08;

   // CP0-to-controller bus: int_pending, status.IE, status.EXL, EPC
   localparam int unsigned CP0_BUS_W = INT_W_DEF + 2 + 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/excp_redirect_ctrl_if.sv
// WB/CP0/fetch signal bundle seen by the commit controller.
interface excp_redirect_ctrl_if
   import excp_redirect_ctrl_pkg::*;
#(
   parameter int unsigned EXCODE_W = EXCODE_W_DEF,
   parameter int unsigned INT_W    = INT_W_DEF
);
   logic                ws_valid;
   logic                ws_ex;
   logic [EXCODE_W-1:0] ws_excode;
   logic                ws_eret;
   logic [31:0]         ws_pc;
   logic [INT_W-1:0]    int_pending;
   logic                status_ie;
   logic                status_exl;
   logic [31:0]         cp0_epc;
   logic                ex_commit;
   logic [EXCODE_W-1:0] ex_code;
   logic                eret_commit;
   logic                ws_cancel;
   logic                ws_block;
   logic                flush;
   logic                redirect_valid;
   logic [31:0]         redirect_pc;
   logic                redirect_ready;

   // Controller side
   modport master (
      input  ws_valid, ws_ex, ws_excode, ws_eret, ws_pc,
      input  int_pending, status_ie, status_exl, cp0_epc, redirect_ready,
      output ex_commit, ex_code, eret_commit, ws_cancel, ws_block,
      output flush, redirect_valid, redirect_pc
   );

   // Pipeline / CP0 / fetch side
   modport slave (
      output ws_valid, ws_ex, ws_excode, ws_eret, ws_pc,
      output int_pending, status_ie, status_exl, cp0_epc, redirect_ready,
      input  ex_commit, ex_code, eret_commit, ws_cancel, ws_block,
      input  flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/excp_redirect_ctrl_sat_counter.sv
// Saturating up-counter for taken exceptions/interrupts.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q;

   // Count up on each increment, sticking at all-ones
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count_q <= '0;
      else if (inc && (count_q != '1))
         count_q <= count_q + 1'b1;
   end

   assign count = count_q;
endmodule

// File: rtl/excp_redirect_ctrl.sv
// Exception/interrupt/ERET commit controller: decides commit kind for the
// WB instruction, sequences a one-cycle flush and holds a redirect to fetch.
module excp_redirect_ctrl
   import excp_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   excp_redirect_ctrl_if.master bus,
   output logic [CNT_W-1:0]     ex_count
);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        int_take;
   logic        req;
   logic        take_ex;
   logic        unused_ws_pc;

   // WB PC is only of interest to statistics outside this block
   assign unused_ws_pc = ^bus.ws_pc;

   // Request decode; gated by resetn so combinational outputs are quiet in reset
   always_comb begin
      int_take = bus.status_ie & ~bus.status_exl & (|bus.int_pending);
      req      = resetn & (state_q == ST_IDLE) & bus.ws_valid
                 & (int_take | bus.ws_ex | bus.ws_eret);
      take_ex  = req & (int_take | bus.ws_ex);
   end

   // State and redirect target registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state, target capture and commit outputs
   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      bus.ex_commit      = take_ex;
      bus.eret_commit    = req & ~take_ex;
      bus.ws_cancel      = take_ex;
      bus.ex_code        = '0;
      bus.ws_block       = (state_q != ST_IDLE);
      bus.flush          = (state_q == ST_FLUSH);
      bus.redirect_valid = (state_q != ST_IDLE);
      bus.redirect_pc    = pc_q;

      if (take_ex && !int_take)
         bus.ex_code = bus.ws_excode;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_FLUSH;
               pc_d    = take_ex ? EX_ENTRY : bus.cp0_epc;
            end
         end
         ST_FLUSH: state_d = bus.redirect_ready ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (bus.redirect_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   sat_counter #(.WIDTH(CNT_W)) u_ex_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (take_ex),
      .count  (ex_count)
   );
endmodule

// File: tb/tb_excp_redirect_ctrl.sv
// Directed self-checking bench for excp_redirect_ctrl.
module tb_excp_redirect_ctrl;
   import excp_redirect_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [15:0] ex_count;
   logic [1:0]  ex_count2;
   int          nvec = 0;
   int          nerr = 0;

   excp_redirect_ctrl_if #(.EXCODE_W(5), .INT_W(8)) bus ();
   excp_redirect_ctrl_if #(.EXCODE_W(5), .INT_W(8)) bus2 ();

   excp_redirect_ctrl #(.EX_ENTRY(32'hbfc00380), .CNT_W(16)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .ex_count(ex_count));

   // Narrow counter instance for reaching saturation in a few requests
   excp_redirect_ctrl #(.EX_ENTRY(32'hbfc00380), .CNT_W(2)) dut2 (
      .clk(clk), .resetn(resetn), .bus(bus2), .ex_count(ex_count2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ws_valid = 0; bus.ws_ex = 0; bus.ws_excode = '0; bus.ws_eret = 0;
      bus.ws_pc = 32'hbfc00000; bus.int_pending = '0; bus.status_ie = 0;
      bus.status_exl = 0; bus.cp0_epc = '0; bus.redirect_ready = 0;
      bus2.ws_valid = 0; bus2.ws_ex = 0; bus2.ws_excode = '0; bus2.ws_eret = 0;
      bus2.ws_pc = '0; bus2.int_pending = '0; bus2.status_ie = 0;
      bus2.status_exl = 0; bus2.cp0_epc = '0; bus2.redirect_ready = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.ws_valid = 1; bus.ws_ex = 1;
      #2;
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL rst_ex_commit got %b want 0", bus.ex_commit); end
      nvec++; if (bus.flush !== 1'b0) begin nerr++; $display("FAIL rst_flush got %b want 0", bus.flush); end
      nvec++; if (bus.redirect_valid !== 1'b0) begin nerr++; $display("FAIL rst_rvalid got %b want 0", bus.redirect_valid); end
      nvec++; if (bus.redirect_pc !== 32'h0) begin nerr++; $display("FAIL rst_rpc got %h want 0", bus.redirect_pc); end
      nvec++; if (ex_count !== 16'h0) begin nerr++; $display("FAIL rst_count got %h want 0", ex_count); end
      nvec++; if (bus.ws_block !== 1'b0) begin nerr++; $display("FAIL rst_block got %b want 0", bus.ws_block); end
      idle_inputs();
      tick(); tick();
      resetn = 1;
   endtask

   task automatic test_exception();
      tick();
      bus.ws_valid = 1; bus.ws_ex = 1; bus.ws_excode = 5'h08; bus.redirect_ready = 1;
      #1;
      nvec++; if (bus.ex_commit !== 1'b1) begin nerr++; $display("FAIL exc_commit got %b want 1", bus.ex_commit); end
      nvec++; if (bus.ex_code !== 5'h08) begin nerr++; $display("FAIL exc_code got %h want 08", bus.ex_code); end
      nvec++; if (bus.ws_cancel !== 1'b1) begin nerr++; $display("FAIL exc_cancel got %b want 1", bus.ws_cancel); end
      nvec++; if (bus.eret_commit !== 1'b0) begin nerr++; $display("FAIL exc_eret got %b want 0", bus.eret_commit); end
      tick();
      bus.ws_valid = 0; bus.ws_ex = 0;
      #1;
      nvec++; if (bus.flush !== 1'b1) begin nerr++; $display("FAIL exc_flush got %b want 1", bus.flush); end
      nvec++; if (bus.redirect_valid !== 1'b1) begin nerr++; $display("FAIL exc_rvalid got %b want 1", bus.redirect_valid); end
      nvec++; if (bus.redirect_pc !== 32'hbfc00380) begin nerr++; $display("FAIL exc_rpc got %h want bfc00380", bus.redirect_pc); end
      nvec++; if (ex_count !== 16'd1) begin nerr++; $display("FAIL exc_count got %0d want 1", ex_count); end
      tick();
      nvec++; if (bus.ws_block !== 1'b0) begin nerr++; $display("FAIL exc_idle_block got %b want 0", bus.ws_block); end
      nvec++; if (bus.redirect_valid !== 1'b0) begin nerr++; $display("FAIL exc_idle_rvalid got %b want 0", bus.redirect_valid); end
   endtask

   task automatic test_eret();
      bus.ws_valid = 1; bus.ws_eret = 1; bus.cp0_epc = 32'hbfc01234; bus.redirect_ready = 0;
      #1;
      nvec++; if (bus.eret_commit !== 1'b1) begin nerr++; $display("FAIL eret_commit got %b want 1", bus.eret_commit); end
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL eret_ex_commit got %b want 0", bus.ex_commit); end
      nvec++; if (bus.ws_cancel !== 1'b0) begin nerr++; $display("FAIL eret_cancel got %b want 0", bus.ws_cancel); end
      tick();
      bus.ws_valid = 0; bus.ws_eret = 0; bus.cp0_epc = 32'h0;
      #1;
      nvec++; if (bus.flush !== 1'b1) begin nerr++; $display("FAIL eret_flush got %b want 1", bus.flush); end
      nvec++; if (bus.redirect_pc !== 32'hbfc01234) begin nerr++; $display("FAIL eret_rpc got %h want bfc01234", bus.redirect_pc); end
      for (int i = 2; i <= 3; i++) begin
         tick();
         nvec++; if (bus.flush !== 1'b0) begin nerr++; $display("FAIL eret_wait_flush T+%0d got %b want 0", i, bus.flush); end
         nvec++; if (bus.redirect_valid !== 1'b1) begin nerr++; $display("FAIL eret_wait_rvalid T+%0d got %b want 1", i, bus.redirect_valid); end
         nvec++; if (bus.redirect_pc !== 32'hbfc01234) begin nerr++; $display("FAIL eret_wait_rpc T+%0d got %h want bfc01234", i, bus.redirect_pc); end
      end
      tick();
      bus.redirect_ready = 1;
      #1;
      nvec++; if (bus.redirect_valid !== 1'b1) begin nerr++; $display("FAIL eret_t4_rvalid got %b want 1", bus.redirect_valid); end
      tick();
      bus.redirect_ready = 0;
      nvec++; if (bus.redirect_valid !== 1'b0) begin nerr++; $display("FAIL eret_done_rvalid got %b want 0", bus.redirect_valid); end
      nvec++; if (ex_count !== 16'd1) begin nerr++; $display("FAIL eret_count got %0d want 1", ex_count); end
   endtask

   task automatic test_interrupt();
      bus.int_pending = 8'h80; bus.status_ie = 1; bus.status_exl = 0;
      bus.ws_valid = 1; bus.ws_ex = 1; bus.ws_excode = 5'h08; bus.redirect_ready = 1;
      #1;
      nvec++; if (bus.ex_commit !== 1'b1) begin nerr++; $display("FAIL int_commit got %b want 1", bus.ex_commit); end
      nvec++; if (bus.ex_code !== 5'h00) begin nerr++; $display("FAIL int_code got %h want 00", bus.ex_code); end
      tick();
      bus.ws_valid = 0;
      nvec++; if (bus.redirect_pc !== 32'hbfc00380) begin nerr++; $display("FAIL int_rpc got %h want bfc00380", bus.redirect_pc); end
      nvec++; if (ex_count !== 16'd2) begin nerr++; $display("FAIL int_count got %0d want 2", ex_count); end
      tick();
      bus.status_exl = 1; bus.ws_valid = 1;
      #1;
      nvec++; if (bus.ex_code !== 5'h08) begin nerr++; $display("FAIL int_exl_code got %h want 08", bus.ex_code); end
      tick();
      bus.ws_valid = 0; bus.ws_ex = 0;
      nvec++; if (ex_count !== 16'd3) begin nerr++; $display("FAIL int_exl_count got %0d want 3", ex_count); end
      tick();
      bus.status_exl = 0;
      #1;
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL int_nobnd_commit got %b want 0", bus.ex_commit); end
      tick();
      nvec++; if (bus.ws_block !== 1'b0) begin nerr++; $display("FAIL int_nobnd_block got %b want 0", bus.ws_block); end
      bus.int_pending = '0; bus.status_ie = 0; bus.redirect_ready = 0;
   endtask

   task automatic test_busy_request();
      bus.ws_valid = 1; bus.ws_ex = 1; bus.ws_excode = 5'h04; bus.redirect_ready = 0;
      #1;
      nvec++; if (bus.ex_code !== 5'h04) begin nerr++; $display("FAIL busy_first_code got %h want 04", bus.ex_code); end
      tick();
      bus.ws_eret = 1;
      #1;
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL busy_flush_ex got %b want 0", bus.ex_commit); end
      nvec++; if (bus.eret_commit !== 1'b0) begin nerr++; $display("FAIL busy_flush_eret got %b want 0", bus.eret_commit); end
      nvec++; if (bus.ws_cancel !== 1'b0) begin nerr++; $display("FAIL busy_flush_cancel got %b want 0", bus.ws_cancel); end
      nvec++; if (bus.ws_block !== 1'b1) begin nerr++; $display("FAIL busy_flush_block got %b want 1", bus.ws_block); end
      tick();
      nvec++; if (bus.flush !== 1'b0) begin nerr++; $display("FAIL busy_wait_flush got %b want 0", bus.flush); end
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL busy_wait_ex got %b want 0", bus.ex_commit); end
      nvec++; if (bus.ws_block !== 1'b1) begin nerr++; $display("FAIL busy_wait_block got %b want 1", bus.ws_block); end
      bus.redirect_ready = 1;
      tick();
      bus.ws_eret = 0; bus.ws_excode = 5'h05;
      #1;
      nvec++; if (bus.ws_block !== 1'b0) begin nerr++; $display("FAIL busy_after_block got %b want 0", bus.ws_block); end
      nvec++; if (bus.ex_commit !== 1'b1) begin nerr++; $display("FAIL busy_after_ex got %b want 1", bus.ex_commit); end
      nvec++; if (bus.ex_code !== 5'h05) begin nerr++; $display("FAIL busy_after_code got %h want 05", bus.ex_code); end
      nvec++; if (ex_count !== 16'd4) begin nerr++; $display("FAIL busy_after_count got %0d want 4", ex_count); end
      tick();
      bus.ws_valid = 0; bus.ws_ex = 0;
      nvec++; if (ex_count !== 16'd5) begin nerr++; $display("FAIL busy_final_count got %0d want 5", ex_count); end
      tick();
      bus.redirect_ready = 0;
   endtask

   task automatic test_reset_in_wait();
      bus.ws_valid = 1; bus.ws_ex = 1; bus.ws_excode = 5'h08;
      tick();
      bus.ws_valid = 0; bus.ws_ex = 0;
      tick();
      nvec++; if (bus.redirect_valid !== 1'b1) begin nerr++; $display("FAIL rstw_pre_rvalid got %b want 1", bus.redirect_valid); end
      #1;
      resetn = 0;
      bus.ws_valid = 1; bus.ws_ex = 1;
      #1;
      nvec++; if (bus.redirect_valid !== 1'b0) begin nerr++; $display("FAIL rstw_rvalid got %b want 0", bus.redirect_valid); end
      nvec++; if (bus.flush !== 1'b0) begin nerr++; $display("FAIL rstw_flush got %b want 0", bus.flush); end
      nvec++; if (ex_count !== 16'd0) begin nerr++; $display("FAIL rstw_count got %0d want 0", ex_count); end
      nvec++; if (bus.ex_commit !== 1'b0) begin nerr++; $display("FAIL rstw_ex got %b want 0", bus.ex_commit); end
      nvec++; if (bus.redirect_pc !== 32'h0) begin nerr++; $display("FAIL rstw_rpc got %h want 0", bus.redirect_pc); end
      bus.ws_valid = 0; bus.ws_ex = 0;
      #1;
      resetn = 1;
      tick();
      nvec++; if (bus.redirect_valid !== 1'b0) begin nerr++; $display("FAIL rstw_after_rvalid got %b want 0", bus.redirect_valid); end
      nvec++; if (bus.ws_block !== 1'b0) begin nerr++; $display("FAIL rstw_after_block got %b want 0", bus.ws_block); end
   endtask

   task automatic test_saturation();
      int exp;
      bus2.redirect_ready = 1;
      for (int k = 1; k <= 5; k++) begin
         bus2.ws_valid = 1; bus2.ws_ex = 1; bus2.ws_excode = 5'h0c;
         tick();
         bus2.ws_valid = 0; bus2.ws_ex = 0;
         exp = (k > 3) ? 3 : k;
         nvec++; if (ex_count2 !== 2'(exp)) begin nerr++; $display("FAIL sat_count k=%0d got %0d want %0d", k, ex_count2, exp); end
         tick();
      end
      bus2.redirect_ready = 0;
   endtask

   initial begin
      test_reset();
      test_exception();
      test_eret();
      test_interrupt();
      test_busy_request();
      test_reset_in_wait();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/excp_redirect_ctrl.md
Name: excp_redirect_ctrl

Overview:
- Exception/interrupt commit controller placed beside the WB stage and CP0 register file.
- Each cycle it decides whether the instruction in WB commits normally, commits as an exception or interrupt, or commits as an ERET.
- On an exception, interrupt or ERET it sequences a pipeline flush, then holds a redirect to the fetch stage under a valid/ready handshake until fetch accepts it.
- It blocks further WB commits while a redirect is outstanding.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception vector address.
- EXCODE_W, 5, exception code width.
- INT_W, 8, interrupt line count (cause.IP & status.IM).
- CNT_W, 16, width of the taken-exception statistics counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  WB holds a valid instruction
- ws_ex  in  1  instruction carries a pipeline exception
- ws_excode  in  EXCODE_W  exception code of ws_ex
- ws_eret  in  1  instruction is ERET
- ws_pc  in  32  PC of WB instruction (passed through unchanged, statistics only)
- int_pending  in  INT_W  cause.IP & status.IM from CP0
- status_ie  in  1  CP0 status.IE
- status_exl  in  1  CP0 status.EXL
- cp0_epc  in  32  CP0 EPC value
- ex_commit  out  1  combinational pulse: CP0 must take the exception this cycle
- ex_code  out  EXCODE_W  final exception code (0 for interrupt)
- eret_commit  out  1  combinational pulse: CP0 must clear EXL this cycle
- ws_cancel  out  1  suppress the regfile/CP0 write of the WB instruction
- ws_block  out  1  WB must not accept a new instruction
- flush  out  1  registered flush to all stages
- redirect_valid  out  1  redirect offered to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect
- ex_count  out  CNT_W  saturating count of taken exceptions and interrupts

Behaviour:
- Reset (resetn=0, async): state IDLE; flush=0, redirect_valid=0, redirect_pc=0, ex_count=0. All combinational outputs are 0 while in reset.
- int_take = status_ie & ~status_exl & (|int_pending).
- A request exists in cycle T when state==IDLE & ws_valid & (int_take | ws_ex | ws_eret).
- Priority: interrupt > ws_ex > ws_eret.
  - Interrupt: ex_commit=1, ex_code=0.
  - ws_ex: ex_commit=1, ex_code=ws_excode.
  - ERET only: eret_commit=1.
  - Exactly one of ex_commit and eret_commit is asserted.
- ws_cancel=1 in T when ex_commit=1. ERET has no register write, so ERET does not assert ws_cancel.
- ws_exl=1 with ws_ex still commits the exception; target is still EX_ENTRY. The CP0 block alone handles EPC/BD preservation.
- Target, latched at the T edge: EX_ENTRY for exceptions and interrupts; cp0_epc sampled in T for ERET.
- States:
  - IDLE: on a request, go to FLUSH.
  - FLUSH: one cycle (T+1); flush=1, redirect_valid=1. If redirect_ready=1, go to IDLE; otherwise go to WAIT.
  - WAIT: flush=0, redirect_valid=1, redirect_pc held stable. When redirect_ready=1, go to IDLE.
- Latency: flush pulse in T+1. Earliest IDLE is T+2. Earliest next request is in T+2.
- ws_block = (state != IDLE), asserted combinationally.
- Requests while not IDLE are ignored: no ex_commit, no eret_commit, no ws_cancel. Such instructions are already flushed.
- redirect_valid, once asserted, never drops before a handshake. redirect_pc must not change while redirect_valid=1.
- ex_count increments by 1 at the T edge of each ex_commit and saturates at all-ones. ERET does not count.
- Reset asserted mid-FLUSH or mid-WAIT returns immediately to IDLE with redirect_valid=0. The pending redirect is discarded.
- ws_valid=0 never produces a request, even with int_take=1. Interrupts are taken only at an instruction boundary.

Decomposition:
- Shared header mycpu.h holds:
  - EXCODE_INT, EXCODE_SYS, EXCODE_ADEL, EXCODE_ADES
  - the EX_ENTRY default
  - state encodings (IDLE=2'd0, FLUSH=2'd1, WAIT=2'd2)
  - the CP0-to-controller bus width macro
- No sub-module is needed except the saturating counter, which is instantiated as sat_counter (width CNT_W, inc, resetn).

Test Plan:
- ws_valid=1, ws_ex=1, ws_excode=5'h08, redirect_ready=1 → ex_commit=1, ex_code=8, ws_cancel=1 in T; flush=1 and redirect_pc=32'hbfc00380 in T+1; IDLE in T+2; ex_count=1.
- ERET with cp0_epc=32'hbfc01234, redirect_ready low for 3 cycles → eret_commit=1, ws_cancel=0 in T; flush only in T+1; redirect_valid high T+1..T+4 with pc stable; ex_count unchanged.
- int_pending=8'h80, status_ie=1, status_exl=0, and ws_ex=1 with excode 8 in the same cycle → ex_code=0 (interrupt wins). Repeat with status_exl=1 → ex_code=8.
- Request arrives during WAIT → no ex_commit/eret_commit, ws_block=1; the request after return to IDLE is accepted normally.
- resetn pulled low in WAIT → redirect_valid=0 and flush=0 immediately, before the clock edge; ex_count=0.
- Preload ex_count to 16'hFFFE and take 3 exceptions → ex_count reads 16'hFFFF and holds.
